btb_predictor: RTL and testbench

Parametrised branch predictor for the pipelined CPU's IF stage: a direct-mapped branch target buffer (BTB) with per-entry direction counters and a selectable prediction mode. It replaces the fixed single-policy predictor. It gives a zero-latency predicted next PC for the fetch PC, learns from branch/jump resolutions reported by ID, and keeps saturating resolution/mispredict statistics.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_ctr_next.sv | 33 +++
 rtl/btb_predictor.sv | 150 +++++++++++++++
 tb/tb_btb_predictor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: mode encodings, 2-bit direction
// counter states and an elaboration-time log2 helper.
package bp_pkg;

  localparam logic [1:0] BP_MODE_STATIC = 2'd0;
  localparam logic [1:0] BP_MODE_BTB    = 2'd1;
  localparam logic [1:0] BP_MODE_SAT    = 2'd2;
  localparam logic [1:0] BP_MODE_HYST   = 2'd3;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Smallest r with 2**r >= value; used only on parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_ctr_next.sv
// Next-state function of a 2-bit direction counter, shared between the BTB
// predictor and the future tournament predictor.
module bp_ctr_next
  import bp_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Hysteresis jumps straight to the strong state; everything else saturates.
  always_comb begin
    ctr_next = ctr;
    case (mode)
      BP_MODE_HYST: begin
        if (taken) begin
          ctr_next = (ctr == CTR_SNT) ? CTR_WNT : CTR_ST;
        end else begin
          ctr_next = (ctr == CTR_ST) ? CTR_WT : CTR_SNT;
        end
      end
      default: begin
        if (taken) begin
          ctr_next = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
          ctr_next = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters: zero-latency
// next-PC prediction for IF, training from ID resolutions, saturating stats.
module btb_predictor
  import bp_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ENTRIES   = 64,
  parameter int MODE      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] fetch_pc,
  output logic [WORD_SIZE-1:0] pred_pc,
  output logic                 pred_hit,
  input  logic                 flush,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_mispredict,
  output logic [15:0]          num_resolved,
  output logic [15:0]          num_mispredict
);

  localparam int         IDX_W  = clog2(ENTRIES);
  localparam int         TAG_W  = WORD_SIZE - IDX_W;
  localparam logic [1:0] MODE_L = 2'(MODE);

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [WORD_SIZE-1:0] target_d [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [1:0]           ctr_d    [ENTRIES];
  logic [15:0]          num_resolved_q, num_resolved_d;
  logic [15:0]          num_mispredict_q, num_mispredict_d;

  logic [IDX_W-1:0] f_idx_s, u_idx_s;
  logic [TAG_W-1:0] f_tag_s, u_tag_s;
  logic             f_hit_s, u_hit_s, f_taken_s, u_taken_s;
  logic [1:0]       ctr_nxt_s;

  assign f_idx_s   = fetch_pc[IDX_W-1:0];
  assign f_tag_s   = fetch_pc[WORD_SIZE-1:IDX_W];
  assign u_idx_s   = upd_pc[IDX_W-1:0];
  assign u_tag_s   = upd_pc[WORD_SIZE-1:IDX_W];
  assign f_hit_s   = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
  assign u_hit_s   = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
  assign u_taken_s = upd_is_jump | upd_taken;

  bp_ctr_next u_ctr_next (
    .mode     (MODE_L),
    .ctr      (ctr_q[u_idx_s]),
    .taken    (u_taken_s),
    .ctr_next (ctr_nxt_s)
  );

  // Combinational lookup so IF sees the prediction in the same cycle.
  always_comb begin
    f_taken_s = 1'b0;
    pred_hit  = 1'b0;
    case (MODE_L)
      BP_MODE_STATIC: begin
        f_taken_s = 1'b0;
        pred_hit  = 1'b0;
      end
      BP_MODE_BTB: begin
        f_taken_s = f_hit_s;
        pred_hit  = f_hit_s;
      end
      default: begin
        f_taken_s = f_hit_s & ctr_q[f_idx_s][1];
        pred_hit  = f_hit_s;
      end
    endcase
    pred_pc = f_taken_s ? target_q[f_idx_s] : fetch_pc + WORD_SIZE'(1);
  end

  // Table training; flush overrides any same-cycle update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid && (MODE_L != BP_MODE_STATIC)) begin
      if (u_taken_s && u_hit_s) begin
        target_d[u_idx_s] = upd_target;
        ctr_d[u_idx_s]    = ctr_nxt_s;
      end else if (u_taken_s) begin
        valid_d[u_idx_s]  = 1'b1;
        tag_d[u_idx_s]    = u_tag_s;
        target_d[u_idx_s] = upd_target;
        ctr_d[u_idx_s]    = upd_is_jump ? CTR_ST : CTR_WT;
      end else if (u_hit_s) begin
        ctr_d[u_idx_s] = ctr_nxt_s;
      end else begin
        ctr_d = ctr_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Saturating statistics, counted even when flush suppresses the write.
  always_comb begin
    num_resolved_d   = num_resolved_q;
    num_mispredict_d = num_mispredict_q;
    if (upd_valid && (num_resolved_q != 16'hFFFF)) begin
      num_resolved_d = num_resolved_q + 16'd1;
    end else begin
      num_resolved_d = num_resolved_q;
    end
    if (upd_valid && upd_mispredict && (num_mispredict_q != 16'hFFFF)) begin
      num_mispredict_d = num_mispredict_q + 16'd1;
    end else begin
      num_mispredict_d = num_mispredict_q;
    end
  end

  // State registers; reset leaves counters weakly not-taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q          <= '0;
      num_resolved_q   <= 16'd0;
      num_mispredict_q <= 16'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q          <= valid_d;
      num_resolved_q   <= num_resolved_d;
      num_mispredict_q <= num_mispredict_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

  assign num_resolved   = num_resolved_q;
  assign num_mispredict = num_mispredict_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: MODE 2 and MODE 3 instances on shared stimulus,
// checked every cycle against an array-based reference model.
module tb_btb_predictor;

  logic        clk, reset_n, flush, upd_valid, upd_is_jump, upd_taken, upd_mispredict;
  logic [15:0] fetch_pc, upd_pc, upd_target;
  logic [15:0] pred_pc2, pred_pc3, res2, res3, mis2, mis3;
  logic        pred_hit2, pred_hit3;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: index 0 is the MODE 2 instance, index 1 the MODE 3 one.
  int m_mode   [2] = '{2, 3};
  bit m_valid  [2][64];
  int m_tag    [2][64];
  int m_target [2][64];
  int m_ctr    [2][64];
  int m_res, m_mis;

  btb_predictor #(.WORD_SIZE(16), .ENTRIES(64), .MODE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .pred_pc(pred_pc2),
    .pred_hit(pred_hit2), .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .num_resolved(res2), .num_mispredict(mis2)
  );

  btb_predictor #(.WORD_SIZE(16), .ENTRIES(64), .MODE(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .pred_pc(pred_pc3),
    .pred_hit(pred_hit3), .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .num_resolved(res3), .num_mispredict(mis3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[k][i] = 1'b0; m_tag[k][i] = 0; m_target[k][i] = 0; m_ctr[k][i] = 1;
      end
    end
    m_res = 0; m_mis = 0;
  endtask

  function automatic int ctr_step(int mode, int c, bit t);
    if (mode == 3) return t ? ((c == 0) ? 1 : 3) : ((c == 3) ? 2 : 0);
    return t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
  endfunction

  function automatic bit exp_hit(int k, logic [15:0] pc);
    int idx = int'(pc) % 64;
    return m_valid[k][idx] && (m_tag[k][idx] == int'(pc) / 64);
  endfunction

  function automatic logic [15:0] exp_pc(int k, logic [15:0] pc);
    int idx = int'(pc) % 64;
    if (exp_hit(k, pc) && m_ctr[k][idx] >= 2) return 16'(m_target[k][idx]);
    return 16'((int'(pc) + 1) % 65536);
  endfunction

  // Applied at each rising edge with the inputs the DUTs sample there.
  task automatic model_update();
    int idx, tg;
    bit t, hit;
    if (!reset_n) return;
    if (upd_valid) begin
      if (m_res < 65535) m_res++;
      if (upd_mispredict && m_mis < 65535) m_mis++;
    end
    for (int k = 0; k < 2; k++) begin
      idx = int'(upd_pc) % 64;
      tg  = int'(upd_pc) / 64;
      t   = upd_is_jump || upd_taken;
      hit = m_valid[k][idx] && (m_tag[k][idx] == tg);
      if (flush) begin
        for (int i = 0; i < 64; i++) m_valid[k][i] = 1'b0;
      end else if (upd_valid) begin
        if (t && hit) begin
          m_target[k][idx] = int'(upd_target);
          m_ctr[k][idx] = ctr_step(m_mode[k], m_ctr[k][idx], 1'b1);
        end else if (t) begin
          m_valid[k][idx] = 1'b1; m_tag[k][idx] = tg;
          m_target[k][idx] = int'(upd_target);
          m_ctr[k][idx] = upd_is_jump ? 3 : 2;
        end else if (hit) begin
          m_ctr[k][idx] = ctr_step(m_mode[k], m_ctr[k][idx], 1'b0);
        end
      end
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pred_pc2",  pred_pc2, exp_pc(0, fetch_pc));
      chk("pred_hit2", 16'(pred_hit2), 16'(exp_hit(0, fetch_pc)));
      chk("pred_pc3",  pred_pc3, exp_pc(1, fetch_pc));
      chk("pred_hit3", 16'(pred_hit3), 16'(exp_hit(1, fetch_pc)));
      chk("res2", res2, 16'(m_res));
      chk("mis2", mis2, 16'(m_mis));
      chk("res3", res3, 16'(m_res));
      chk("mis3", mis3, 16'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [15:0] pc, input logic j,
                         input logic t, input logic [15:0] tgt, input logic mp);
    upd_valid = v; upd_pc = pc; upd_is_jump = j; upd_taken = t;
    upd_target = tgt; upd_mispredict = mp;
  endtask

  function automatic logic [15:0] rnd_pc();
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
  endfunction

  task automatic rnd_cycle(input bit force_upd);
    fetch_pc = rnd_pc();
    flush = ($urandom_range(0, 31) == 0);
    set_upd(force_upd || $urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, 16'($urandom), force_upd || $urandom_range(0, 9) < 3);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; fetch_pc = 16'h0010;
    set_upd(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    model_reset();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_pc", pred_pc2, 16'h0011);
    chk("rst_hit", 16'(pred_hit2), 16'h0000);
    chk("rst_res", res2, 16'h0000);
    chk("rst_mis", mis2, 16'h0000);
    reset_n = 1'b1;

    // Learn then weaken one entry.
    fetch_pc = 16'h0000;
    set_upd(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0030, 1'b0);
    tick();
    set_upd(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    fetch_pc = 16'h0010; #2;
    chk("learn_pc", pred_pc2, 16'h0030);
    chk("learn_hit", 16'(pred_hit2), 16'h0001);
    set_upd(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    set_upd(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2;
    chk("unlearn_pc", pred_pc2, 16'h0011);
    chk("unlearn_hit", 16'(pred_hit2), 16'h0001);

    // Aliasing tag and PC wrap.
    fetch_pc = 16'h0050; #2;
    chk("alias_hit", 16'(pred_hit2), 16'h0000);
    chk("alias_pc", pred_pc2, 16'h0051);
    fetch_pc = 16'hFFFF; #2;
    chk("wrap_pc", pred_pc2, 16'h0000);

    // Same-cycle lookup sees pre-update state.
    fetch_pc = 16'h0020;
    set_upd(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0040, 1'b0);
    #2;
    chk("same_pre", pred_pc2, 16'h0021);
    tick();
    set_upd(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2;
    chk("same_post", pred_pc2, 16'h0040);

    // Flush beats a same-cycle update, statistics still count it.
    fetch_pc = 16'h0008; flush = 1'b1;
    set_upd(1'b1, 16'h0008, 1'b0, 1'b1, 16'h0070, 1'b0);
    tick();
    flush = 1'b0;
    set_upd(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2;
    chk("flush_pc", pred_pc2, 16'h0009);
    chk("flush_res", res2, 16'h0004);
    fetch_pc = 16'h0020; #2;
    chk("flush_clr", pred_pc2, 16'h0021);

    // Hysteresis: taken, taken, not-taken leaves weakly taken.
    fetch_pc = 16'h0000;
    set_upd(1'b1, 16'h0005, 1'b0, 1'b1, 16'h0123, 1'b0); tick();
    set_upd(1'b1, 16'h0005, 1'b0, 1'b1, 16'h0123, 1'b0); tick();
    set_upd(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0); tick();
    set_upd(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    fetch_pc = 16'h0005; #2;
    chk("hyst_pc", pred_pc3, 16'h0123);
    chk("hyst_hit", 16'(pred_hit3), 16'h0001);

    for (int i = 0; i < 2000; i++) rnd_cycle(1'b0);

    // Statistics saturation, then asynchronous clear.
    for (int i = 0; i < 65540; i++) rnd_cycle(1'b1);
    #2;
    chk("sat_res", res2, 16'hFFFF);
    chk("sat_mis", mis2, 16'hFFFF);
    rnd_cycle(1'b1); rnd_cycle(1'b1);
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("async_res", res2, 16'h0000);
    chk("async_mis", mis2, 16'h0000);
    chk("async_hit", 16'(pred_hit2), 16'h0000);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) rnd_cycle(1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
